// File: rtl/modexp_loader_pkg.sv
// Shared ModExp parameters: word/operand widths and the exponentiation state codes
// reported by ModExp on exp_state, plus the loader FSM state encodings.
package modexp_loader_pkg;

  localparam int MX_DATA_WIDTH = 64;
  localparam int MX_WIDTH      = 4096;
  localparam int MX_WORDS      = MX_WIDTH / MX_DATA_WIDTH;

  // ModExp exponentiation states; only EXP_COMPLETE is consumed by the loader
  localparam logic [4:0] EXP_INIT_STATE = 5'd0;
  localparam logic [4:0] EXP_LOAD       = 5'd1;
  localparam logic [4:0] EXP_PRECOMP    = 5'd2;
  localparam logic [4:0] EXP_SQUARE     = 5'd3;
  localparam logic [4:0] EXP_MULTIPLY   = 5'd4;
  localparam logic [4:0] EXP_REDUCE     = 5'd5;
  localparam logic [4:0] EXP_FINAL_MUL  = 5'd6;
  localparam logic [4:0] EXP_CONVERT    = 5'd7;
  localparam logic [4:0] EXP_OUTPUT     = 5'd8;
  localparam logic [4:0] EXP_COMPLETE   = 5'd9;
  localparam logic [4:0] EXP_TERMINAL   = 5'd10;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_COMPUTE = 3'd2;
  localparam logic [2:0] ST_READ    = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

endpackage

// File: rtl/modexp_loader.sv
// Streams five wide operands into ModExp word by word, waits for completion and
// reassembles the word-serial result into a single wide register.
module modexp_loader
  import modexp_loader_pkg::*;
#(
  parameter int         DATA_WIDTH    = MX_DATA_WIDTH,
  parameter int         WIDTH         = MX_WIDTH,
  parameter logic [4:0] COMPLETE_CODE = EXP_COMPLETE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  go,
  input  logic [WIDTH-1:0]      message,
  input  logic [WIDTH-1:0]      exponent,
  input  logic [WIDTH-1:0]      modulus,
  input  logic [WIDTH-1:0]      r,
  input  logic [WIDTH-1:0]      t,
  input  logic [63:0]           nprime0_in,
  input  logic [4:0]            exp_state,
  input  logic [DATA_WIDTH-1:0] res_out,
  output logic [DATA_WIDTH-1:0] m_buf,
  output logic [DATA_WIDTH-1:0] e_buf,
  output logic [DATA_WIDTH-1:0] n_buf,
  output logic [DATA_WIDTH-1:0] r_buf,
  output logic [DATA_WIDTH-1:0] t_buf,
  output logic [63:0]           nprime0,
  output logic                  startInput,
  output logic                  startCompute,
  output logic                  getResult,
  output logic [WIDTH-1:0]      result,
  output logic                  busy,
  output logic                  done
);

  localparam int WORDS = WIDTH / DATA_WIDTH;
  localparam int CNT_W = $clog2(WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_LD = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(WORDS);

  logic [2:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_m_buf, r_e_buf, r_n_buf, r_r_buf, r_t_buf;
  logic [63:0]           r_nprime0;
  logic                  r_start_input, r_start_compute, r_get_result;
  logic [WIDTH-1:0]      r_result;
  logic                  r_busy, r_done;

  int                    w_ld_word;
  int                    w_rd_word;
  logic [DATA_WIDTH-1:0] w_m_word, w_e_word, w_n_word, w_r_word, w_t_word;

  // Buffers are registered, so the word selected now is the one shown next cycle
  always_comb begin
    w_ld_word = 0;
    if (r_state == ST_LOAD && r_cnt != LAST_LD) w_ld_word = int'(r_cnt) + 1;
    w_rd_word = (r_cnt == '0) ? 0 : int'(r_cnt) - 1;
  end

  assign w_m_word = message[w_ld_word*DATA_WIDTH +: DATA_WIDTH];
  assign w_e_word = exponent[w_ld_word*DATA_WIDTH +: DATA_WIDTH];
  assign w_n_word = modulus[w_ld_word*DATA_WIDTH +: DATA_WIDTH];
  assign w_r_word = r[w_ld_word*DATA_WIDTH +: DATA_WIDTH];
  assign w_t_word = t[w_ld_word*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_IDLE;
      r_cnt           <= '0;
      r_m_buf         <= '0;
      r_e_buf         <= '0;
      r_n_buf         <= '0;
      r_r_buf         <= '0;
      r_t_buf         <= '0;
      r_nprime0       <= '0;
      r_start_input   <= 1'b0;
      r_start_compute <= 1'b0;
      r_get_result    <= 1'b0;
      r_result        <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (go) begin
            r_state       <= ST_LOAD;
            r_cnt         <= '0;
            r_nprime0     <= nprime0_in;
            r_busy        <= 1'b1;
            r_start_input <= 1'b1;
            r_m_buf       <= w_m_word;
            r_e_buf       <= w_e_word;
            r_n_buf       <= w_n_word;
            r_r_buf       <= w_r_word;
            r_t_buf       <= w_t_word;
          end
        end
        ST_LOAD: begin
          if (r_cnt == LAST_LD) begin
            r_state         <= ST_COMPUTE;
            r_cnt           <= '0;
            r_start_input   <= 1'b0;
            r_start_compute <= 1'b1;
            r_get_result    <= 1'b1;
            r_m_buf         <= '0;
            r_e_buf         <= '0;
            r_n_buf         <= '0;
            r_r_buf         <= '0;
            r_t_buf         <= '0;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_m_buf <= w_m_word;
            r_e_buf <= w_e_word;
            r_n_buf <= w_n_word;
            r_r_buf <= w_r_word;
            r_t_buf <= w_t_word;
          end
        end
        ST_COMPUTE: begin
          if (exp_state == COMPLETE_CODE) begin
            r_state <= ST_READ;
            r_cnt   <= '0;
          end
        end
        ST_READ: begin
          // READ cycle 0 carries ModExp's pipeline latency, not result data
          if (r_cnt != '0) r_result[w_rd_word*DATA_WIDTH +: DATA_WIDTH] <= res_out;
          if (r_cnt == LAST_RD) begin
            r_state         <= ST_DONE;
            r_start_compute <= 1'b0;
            r_get_result    <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_buf        = r_m_buf;
  assign e_buf        = r_e_buf;
  assign n_buf        = r_n_buf;
  assign r_buf        = r_r_buf;
  assign t_buf        = r_t_buf;
  assign nprime0      = r_nprime0;
  assign startInput   = r_start_input;
  assign startCompute = r_start_compute;
  assign getResult    = r_get_result;
  assign result       = r_result;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule
